// File: rtl/brc_pkg.sv
// Shared branch-compare types and decode helpers for the RV32I branch resolver.
package brc_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    function automatic logic is_unsigned(input logic [2:0] funct3);
        return funct3[1];
    endfunction

    // 010 and 011 are the only funct3 codes with no branch meaning.
    function automatic logic is_illegal(input logic [2:0] funct3);
        return funct3[2:1] == 2'b01;
    endfunction

    function automatic logic br_taken(input logic [2:0] funct3, input logic less,
                                      input logic equal);
        logic taken;
        case (br_funct3_e'(funct3))
            BEQ:        taken = equal;
            BNE:        taken = !equal;
            BLT, BLTU:  taken = less;
            BGE, BGEU:  taken = !less;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/brc_pipe_stage.sv
// Generic valid/ready register slice; full throughput via combinational ready.
module brc_pipe_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        o_ready = !valid_q || i_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (o_ready) begin
            valid_d = i_valid;
            if (i_valid) data_d = i_data;
        end
        // Flush only kills the valid bit; the payload is left as-is.
        if (i_flush) valid_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/brc_pipe.sv
// Pipelined branch comparator/resolver; LAT=1 full compare, LAT=2 split half-word compare.
module brc_pipe
    import brc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LAT   = 1,
    parameter int TAG_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic [2:0]       i_funct3,
    input  logic             i_pred_taken,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal,
    output logic             o_taken,
    output logic             o_mispredict,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);

    localparam int H     = WIDTH / 2;
    localparam int RES_W = 5 + TAG_W;

    logic [RES_W-1:0] res_q;

    assign {o_br_less, o_br_equal, o_taken, o_mispredict, o_illegal, o_tag} = res_q;

    if (LAT == 1) begin : g_lat1
        logic             less, equal, taken, illegal;
        logic [RES_W-1:0] res_d;

        always_comb begin
            if (is_unsigned(i_funct3)) less = i_rs1_data < i_rs2_data;
            else                       less = $signed(i_rs1_data) < $signed(i_rs2_data);
            equal   = i_rs1_data == i_rs2_data;
            taken   = br_taken(i_funct3, less, equal);
            illegal = is_illegal(i_funct3);
            res_d   = {less, equal, taken, !illegal && (taken != i_pred_taken), illegal, i_tag};
        end

        brc_pipe_stage #(.W(RES_W)) u_s1 (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_flush (i_flush),
            .i_valid (i_valid),
            .o_ready (o_ready),
            .i_data  (res_d),
            .o_valid (o_valid),
            .i_ready (i_ready),
            .o_data  (res_q)
        );
    end else begin : g_lat2
        localparam int MID_W = 4 + 3 + 1 + TAG_W;

        logic             eq_hi, eq_lo, lt_hi, lt_lo;
        logic [MID_W-1:0] mid_d, mid_q;
        logic             mid_valid, mid_ready;
        logic             m_eq_hi, m_eq_lo, m_lt_hi, m_lt_lo, m_pred;
        logic [2:0]       m_funct3;
        logic [TAG_W-1:0] m_tag;
        logic             less, equal, taken, illegal;
        logic [RES_W-1:0] res_d;

        // Only the upper half carries the sign; the lower half is always a magnitude.
        always_comb begin
            eq_hi = i_rs1_data[WIDTH-1:H] == i_rs2_data[WIDTH-1:H];
            eq_lo = i_rs1_data[H-1:0] == i_rs2_data[H-1:0];
            lt_lo = i_rs1_data[H-1:0] < i_rs2_data[H-1:0];
            if (is_unsigned(i_funct3))
                lt_hi = i_rs1_data[WIDTH-1:H] < i_rs2_data[WIDTH-1:H];
            else
                lt_hi = $signed(i_rs1_data[WIDTH-1:H]) < $signed(i_rs2_data[WIDTH-1:H]);
            mid_d = {eq_hi, eq_lo, lt_hi, lt_lo, i_funct3, i_pred_taken, i_tag};
        end

        brc_pipe_stage #(.W(MID_W)) u_s1 (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_flush (i_flush),
            .i_valid (i_valid),
            .o_ready (o_ready),
            .i_data  (mid_d),
            .o_valid (mid_valid),
            .i_ready (mid_ready),
            .o_data  (mid_q)
        );

        always_comb begin
            {m_eq_hi, m_eq_lo, m_lt_hi, m_lt_lo, m_funct3, m_pred, m_tag} = mid_q;
            equal   = m_eq_hi & m_eq_lo;
            less    = m_lt_hi | (m_eq_hi & m_lt_lo);
            taken   = br_taken(m_funct3, less, equal);
            illegal = is_illegal(m_funct3);
            res_d   = {less, equal, taken, !illegal && (taken != m_pred), illegal, m_tag};
        end

        brc_pipe_stage #(.W(RES_W)) u_s2 (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_flush (i_flush),
            .i_valid (mid_valid),
            .o_ready (mid_ready),
            .i_data  (res_d),
            .o_valid (o_valid),
            .i_ready (i_ready),
            .o_data  (res_q)
        );
    end

endmodule

// File: tb/tb_brc_pipe.sv
// Drives a LAT=1 and a LAT=2 brc_pipe with shared stimulus against a queue-based model.
module tb_brc_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vin, flush, rdy, pred;
    logic [31:0] a, b;
    logic [2:0]  f3;
    logic [7:0]  tag;

    logic [1:0]      ov, ordy, ol, oe, ot, om, oi;
    logic [1:0][7:0] otg;

    brc_pipe #(.WIDTH(32), .LAT(1), .TAG_W(8)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_valid(vin), .o_ready(ordy[0]),
        .i_rs1_data(a), .i_rs2_data(b), .i_funct3(f3), .i_pred_taken(pred),
        .i_tag(tag), .i_flush(flush), .o_valid(ov[0]), .i_ready(rdy),
        .o_br_less(ol[0]), .o_br_equal(oe[0]), .o_taken(ot[0]),
        .o_mispredict(om[0]), .o_illegal(oi[0]), .o_tag(otg[0])
    );

    brc_pipe #(.WIDTH(32), .LAT(2), .TAG_W(8)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_valid(vin), .o_ready(ordy[1]),
        .i_rs1_data(a), .i_rs2_data(b), .i_funct3(f3), .i_pred_taken(pred),
        .i_tag(tag), .i_flush(flush), .o_valid(ov[1]), .i_ready(rdy),
        .o_br_less(ol[1]), .o_br_equal(oe[1]), .o_taken(ot[1]),
        .o_mispredict(om[1]), .o_illegal(oi[1]), .o_tag(otg[1])
    );

    typedef struct {
        logic [4:0] flags;  // {less, equal, taken, mispredict, illegal}
        logic [7:0] tag;
        int         vis;    // first cycle the result may be seen
    } item_t;

    item_t mq[2][4];
    int    mh[2], mc[2], act_dep[2];
    int    cyc, n_chk, n_fail;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic item_t model();
        item_t it;
        logic  less, eq, tk, ill;
        less = f3[1] ? (a < b) : ($signed(a) < $signed(b));
        eq   = (a == b);
        ill  = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'd0:       tk = eq;
            3'd1:       tk = !eq;
            3'd4, 3'd6: tk = less;
            3'd5, 3'd7: tk = !less;
            default:    tk = 1'b0;
        endcase
        it.flags = {less, eq, tk, !ill && (tk != pred), ill};
        it.tag   = tag;
        it.vis   = 0;
        return it;
    endfunction

    // Check the current cycle for both pipes, advance the model across the edge.
    task automatic step();
        logic  er, hv;
        item_t it;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mc[d] = 0;
                mh[d] = 0;
                continue;
            end
            er = !(mc[d] == d + 1 && !rdy);
            hv = mc[d] > 0 && mq[d][mh[d]].vis <= cyc;
            check($sformatf("L%0d_o_ready", d + 1), ordy[d], er);
            check($sformatf("L%0d_o_valid", d + 1), ov[d], hv);
            if (hv) begin
                check($sformatf("L%0d_flags", d + 1), {ol[d], oe[d], ot[d], om[d], oi[d]},
                      mq[d][mh[d]].flags);
                check($sformatf("L%0d_tag", d + 1), otg[d], mq[d][mh[d]].tag);
            end
            if (ov[d] && rdy) act_dep[d]++;
            if (hv && rdy) begin
                mh[d] = (mh[d] + 1) % 4;
                mc[d]--;
                if (mc[d] > 0 && mq[d][mh[d]].vis < cyc + 1) mq[d][mh[d]].vis = cyc + 1;
            end
            if (flush) mc[d] = 0;
            else if (vin && er) begin
                it     = model();
                it.vis = cyc + d + 1;
                mq[d][(mh[d] + mc[d]) % 4] = it;
                mc[d]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic op(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                      input logic p, input logic [7:0] t);
        vin = 1'b1; f3 = f; a = aa; b = bb; pred = p; tag = t;
        step();
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        repeat (n) step();
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {ov, ol, oe, ot, om, oi, otg}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int d0, d1;
        logic [2:0] legal [6];
        legal = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        n_chk = 0; n_fail = 0; cyc = 0;
        mh = '{0, 0}; mc = '{0, 0}; act_dep = '{0, 0};
        rst = 1'b1; vin = 1'b0; flush = 1'b0; rdy = 1'b1;
        a = '0; b = '0; f3 = '0; pred = 1'b0; tag = '0;

        step();
        step();
        check_reset_outputs("reset_outputs");
        rst = 1'b0;
        step();

        // Directed compares, back-to-back
        op(3'd0, 32'd5, 32'd5, 1'b0, 8'h01);
        op(3'd4, 32'hFFFF_FFFD, 32'd2, 1'b1, 8'h02);
        op(3'd6, 32'hFFFF_FFFD, 32'd2, 1'b1, 8'h03);
        op(3'd5, 32'd7, 32'hFFFF_FFFF, 1'b0, 8'h04);
        idle(3);

        // Carry across the half-word split
        op(3'd6, 32'h0001_0000, 32'h0000_FFFF, 1'b0, 8'h05);
        op(3'd4, 32'h8000_0000, 32'h0000_0001, 1'b0, 8'h06);
        op(3'd0, 32'h1234_0001, 32'h1234_0000, 1'b1, 8'h07);
        op(3'd7, 32'h8000_0000, 32'h0000_0001, 1'b1, 8'h08);
        idle(3);

        // 10 back-to-back ops drain within 12 cycles
        d0 = act_dep[0];
        d1 = act_dep[1];
        for (int i = 0; i < 10; i++)
            op(legal[$urandom % 6], pick(), pick(), 1'($urandom), 8'h20 + 8'(i));
        idle(2);
        check("b2b_lat1_count", act_dep[0] - d0, 10);
        check("b2b_lat2_count", act_dep[1] - d1, 10);

        // Back-pressure with continuous input
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) op(3'd1, 32'(i), 32'd2, 1'b0, 8'h40 + 8'(i));
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) op(3'd4, 32'd1, 32'(i), 1'b1, 8'h48 + 8'(i));
        idle(4);

        // Mispredict and illegal
        op(3'd1, 32'd4, 32'd4, 1'b1, 8'h50);
        op(3'd3, 32'd9, 32'd9, 1'b1, 8'h51);
        op(3'd2, 32'd1, 32'd9, 1'b0, 8'h52);
        idle(3);

        // Flush a stalled, full pipe together with a new input
        rdy = 1'b0;
        op(3'd0, 32'd1, 32'd1, 1'b0, 8'h11);
        op(3'd1, 32'd1, 32'd2, 1'b0, 8'h22);
        flush = 1'b1;
        op(3'd4, 32'd1, 32'd2, 1'b0, 8'h33);
        flush = 1'b0;
        vin = 1'b0;
        check("flush_o_valid", ov, 2'b00);
        rdy = 1'b1;
        idle(4);

        // Reset with operations in flight
        op(3'd0, 32'd3, 32'd3, 1'b0, 8'h60);
        op(3'd0, 32'd3, 32'd4, 1'b0, 8'h61);
        rst = 1'b1;
        vin = 1'b0;
        step();
        check_reset_outputs("midreset_outputs");
        rst = 1'b0;
        step();
        idle(2);

        // Random traffic
        repeat (1500) begin
            vin   = ($urandom % 4) != 0;
            rdy   = ($urandom % 3) != 0;
            flush = ($urandom % 20) == 0;
            f3    = 3'($urandom);
            a     = pick();
            b     = (($urandom % 3) == 0) ? a : pick();
            pred  = 1'($urandom);
            tag   = 8'($urandom);
            step();
        end
        flush = 1'b0;
        rdy = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
